// File: rtl/std_fp_mult_pipe_arbiter_if.sv
// rtl/std_fp_mult_pipe_arbiter_if.sv - requester, response and multiplier bus bundle for std_fp_mult_pipe_arbiter
//
// Purpose: groups every handshake/bus signal of the arbiter so the arbiter
// and its environment connect through one port.
//
// Signals:
//   req_valid  [NREQ]        per-requester operand valid, held until accepted
//   req_ready  [NREQ]        one-hot accept (combinational)
//   req_left   [NREQ*WIDTH]  flattened left operands, slice i = [i*WIDTH +: WIDTH]
//   req_right  [NREQ*WIDTH]  flattened right operands, same slicing
//   rsp_valid / rsp_ready    result handshake
//   rsp_id     [IDW]         owner of rsp_data
//   rsp_data   [WIDTH]       registered multiplier result
//   rsp_err                  watchdog abort flag, data invalid when set
//   mul_go, mul_reset, mul_left, mul_right   towards the multiplier
//   mul_out, mul_done                        from the multiplier
//   busy                     arbiter is not idle
//
// Modports: slave = arbiter side, master = environment side.

interface std_fp_mult_pipe_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_left;
  logic [NREQ*WIDTH-1:0] req_right;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  mul_go;
  logic                  mul_reset;
  logic [WIDTH-1:0]      mul_left;
  logic [WIDTH-1:0]      mul_right;
  logic [WIDTH-1:0]      mul_out;
  logic                  mul_done;
  logic                  busy;

  modport slave (
    input  req_valid, req_left, req_right, rsp_ready, mul_out, mul_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           mul_go, mul_reset, mul_left, mul_right, busy
  );

  modport master (
    output req_valid, req_left, req_right, rsp_ready, mul_out, mul_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           mul_go, mul_reset, mul_left, mul_right, busy
  );
endinterface

// File: rtl/std_fp_mult_pipe_arbiter.sv
// rtl/std_fp_mult_pipe_arbiter.sv - round-robin sharing of one pipelined multiplier among NREQ requesters
//
// Purpose: grants one requester at a time (round robin from rr_ptr), captures
// its operands, holds mul_go until mul_done, and keeps the tagged result in a
// single-entry buffer until the consumer takes it.
//
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      std_fp_mult_pipe_arbiter_if.slave (requests, response, multiplier)
//
// Optional feature: define STD_FP_MULT_ARB_WATCHDOG_EN to enable a BUSY
// watchdog (parameter MAX_LAT). On expiry the multiplier is reset and an
// error response with zero data is returned. Without the macro rsp_err is 0
// and BUSY waits for mul_done indefinitely.

module std_fp_mult_pipe_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
`ifdef STD_FP_MULT_ARB_WATCHDOG_EN
  parameter int MAX_LAT = 8,
`endif
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  std_fp_mult_pipe_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             mul_go_q, mul_go_d;
  logic             mul_reset_q, mul_reset_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
`ifdef STD_FP_MULT_ARB_WATCHDOG_EN
  localparam int CW = $clog2(MAX_LAT + 1);
  logic             rsp_err_q, rsp_err_d;
  logic [CW-1:0]    wd_cnt_q, wd_cnt_d;
`endif

  // Round-robin search: walk candidates from the farthest to rr_ptr itself so
  // the last hit written is the first valid index at or after rr_ptr.
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic           grant_en;
  logic [IDW-1:0] rr_next;
  logic [NREQ-1:0] req_ready_w;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (bus.req_valid[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  // No grant while the multiplier is still held in reset.
  assign grant_en = (state_q == S_IDLE) && !mul_reset_q && grant_any;
  assign rr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  always_comb begin
    req_ready_w = '0;
    if (grant_en) begin
      req_ready_w[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    mul_go_d    = mul_go_q;
    mul_reset_d = 1'b0;
    left_d      = left_q;
    right_d     = right_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
`ifdef STD_FP_MULT_ARB_WATCHDOG_EN
    rsp_err_d   = rsp_err_q;
    wd_cnt_d    = wd_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          left_d   = bus.req_left[int'(grant_idx)*WIDTH +: WIDTH];
          right_d  = bus.req_right[int'(grant_idx)*WIDTH +: WIDTH];
          rsp_id_d = grant_idx;
          rr_ptr_d = rr_next;
          mul_go_d = 1'b1;
          state_d  = S_BUSY;
`ifdef STD_FP_MULT_ARB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
        end
      end
      S_BUSY: begin
        if (bus.mul_done) begin
          rsp_data_d  = bus.mul_out;
          rsp_valid_d = 1'b1;
          mul_go_d    = 1'b0;
          state_d     = S_RESP;
`ifdef STD_FP_MULT_ARB_WATCHDOG_EN
        end else if (wd_cnt_q == CW'(MAX_LAT - 1)) begin
          // This is the MAX_LAT-th BUSY cycle without done: abort the op and
          // flush the multiplier pipe.
          mul_go_d    = 1'b0;
          mul_reset_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + CW'(1);
`endif
        end
      end
      S_RESP: begin
        // go stays low here for at least one cycle, clearing the done pipe.
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
`ifdef STD_FP_MULT_ARB_WATCHDOG_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      mul_go_q    <= 1'b0;
      mul_reset_q <= 1'b1;
      left_q      <= '0;
      right_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef STD_FP_MULT_ARB_WATCHDOG_EN
      rsp_err_q   <= 1'b0;
      wd_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      mul_go_q    <= mul_go_d;
      mul_reset_q <= mul_reset_d;
      left_q      <= left_d;
      right_q     <= right_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifdef STD_FP_MULT_ARB_WATCHDOG_EN
      rsp_err_q   <= rsp_err_d;
      wd_cnt_q    <= wd_cnt_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef STD_FP_MULT_ARB_WATCHDOG_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign bus.mul_go    = mul_go_q;
  assign bus.mul_reset = mul_reset_q;
  assign bus.mul_left  = left_q;
  assign bus.mul_right = right_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
